// File: rtl/wb_pkg.sv
// Shared writeback definitions: register index types, the writeback request struct and the
// common 5-to-32 register-enable decoder.
package wb_pkg;

    localparam int unsigned REG_IDX_W      = 5;
    localparam int unsigned NUM_ARCH_REGS  = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t                  rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_ARCH_REGS-1:0] decode_rd(input reg_idx_t rd);
        logic [NUM_ARCH_REGS-1:0] dec;
        dec     = '0;
        dec[rd] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way one-hot arbiter with a rotating priority pointer.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest, no pointer register).
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    input  logic         upd_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] gnt_idx;
    logic [PtrW:0]   idx_sum;
    logic [PtrW-1:0] idx;
    logic            found;

    // Circular scan starting at the pointer; first valid requester wins.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx_sum = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_sum = {1'b0, ptr} + (PtrW+1)'(k);
            if (idx_sum >= (PtrW+1)'(N)) begin
                idx_sum = idx_sum - (PtrW+1)'(N);
            end
            idx = idx_sum[PtrW-1:0];
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    assign ptr = '0;

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, upd_i, gnt_idx};
`else
    logic [PtrW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: one-hot grant among writeback requesters, then a one-cycle
// writeback stage. Define WB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][REG_IDX_W-1:0]    req_rd,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 stall,
    output logic                                 wb_valid,
    output logic [REG_IDX_W-1:0]                 wb_rd,
    output logic [NUM_ARCH_REGS-1:0]             wb_we,
    output logic [DATA_W-1:0]                    wb_data
);

    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    reg_idx_t           win_rd;
    logic [DATA_W-1:0]  win_data;

    logic               wb_valid_q;
    reg_idx_t           wb_rd_q;
    logic [DATA_W-1:0]  wb_data_q;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .en_i  (~stall & ~rst),
        .upd_i (accept),
        .gnt_o (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_rd   = win_rd | req_rd[i];
                win_data = win_data | req_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= accept;
            if (accept) begin
                wb_rd_q   <= win_rd;
                wb_data_q <= win_data;
            end
        end
    end

    // r0 is hardwired zero: an accepted r0 write occupies the slot but enables nothing.
    always_comb begin
        wb_we = '0;
        if (wb_valid_q) begin
            wb_we = decode_rd(wb_rd_q);
        end
        wb_we[0] = 1'b0;
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic against a
// priority-scan reference model with a shadow register file.
module tb_wb_port_arbiter;

    localparam int N = 3;
    localparam int W = 32;
`ifdef WB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0][4:0]     req_rd;
    logic [N-1:0][W-1:0]   req_data;
    logic [N-1:0]          req_ready;
    logic                  stall;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [31:0]           wb_we;
    logic [W-1:0]          wb_data;

    wb_port_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_we     (wb_we),
        .wb_data   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int         m_ptr;
    bit         m_wb_valid;
    logic [4:0] m_wb_rd;
    logic [W-1:0] m_wb_data;
    logic [W-1:0] rf [32];
    int         last_grant;
    logic [N-1:0] obs_ready;
    logic [31:0]  obs_we;
    logic [W-1:0] obs_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (rst || stall) return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: inputs already applied; check mid-cycle, then advance the model.
    task automatic cycle();
        int g;
        logic [N-1:0]  exp_ready;
        logic [31:0]   exp_we;
        @(negedge clk);
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_we = '0;
        if (m_wb_valid && m_wb_rd != 0) exp_we[m_wb_rd] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
        check_eq("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
        check_eq("wb_we", 64'(wb_we), 64'(exp_we));
        check_eq("wb_data", 64'(wb_data), 64'(m_wb_data));
        obs_ready = req_ready;
        obs_we    = wb_we;
        obs_data  = wb_data;
        if (m_wb_valid && m_wb_rd != 0) rf[m_wb_rd] = m_wb_data;
        if (rst) begin
            m_ptr = 0; m_wb_valid = 0; m_wb_rd = '0; m_wb_data = '0;
        end else begin
            m_wb_valid = (g >= 0);
            if (g >= 0) begin
                m_wb_rd   = req_rd[g];
                m_wb_data = req_data[g];
                m_ptr     = FIXED ? 0 : (g + 1) % N;
            end
        end
        last_grant = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1; stall = 1'b0;
        req_valid = '1;
        req_rd = '0; req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_rd[i]   = 5'(i + 1);
            req_data[i] = W'(32'hA000 + i);
        end
        @(posedge clk); #1;
        m_ptr = 0; m_wb_valid = 0; m_wb_rd = '0; m_wb_data = '0;

        // Reset with all requesters valid.
        repeat (3) begin
            cycle();
            check_eq("rst_ready", 64'(obs_ready), 64'd0);
        end
        rst = 1'b0;
        req_valid = '0;
        cycle();
        check_eq("rst_wb_we", 64'(obs_we), 64'd0);

        // Round-robin from ptr=0.
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_eq("rr_grant", 64'(obs_ready), 64'(3'b001 << (FIXED ? 0 : c % 3)));
        end
        req_valid = '0;
        cycle();

        // Single request from requester 0.
        req_valid = 3'b001; req_rd[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
        cycle();
        check_eq("single_ready", 64'(obs_ready), 64'b001);
        req_valid = '0;
        cycle();
        check_eq("single_we", 64'(obs_we), 64'h0000_0020);
        check_eq("single_data", 64'(obs_data), 64'hDEADBEEF);

        // r0 write from requester 1: accepted, writes nothing.
        req_valid = 3'b010; req_rd[1] = 5'd0; req_data[1] = 32'h1234;
        cycle();
        check_eq("r0_ready", 64'(obs_ready), 64'b010);
        req_valid = 3'b111;
        cycle();
        check_eq("r0_we", 64'(obs_we), 64'd0);
        check_eq("r0_ptr_adv", 64'(obs_ready), FIXED ? 64'b001 : 64'b100);
        req_valid = '0;
        cycle();

        // Stall for three cycles with requester 1 pending.
        req_valid = 3'b010; req_rd[1] = 5'd9; req_data[1] = 32'h5555;
        stall = 1'b1;
        repeat (3) begin
            cycle();
            check_eq("stall_ready", 64'(obs_ready), 64'd0);
        end
        stall = 1'b0;
        cycle();
        check_eq("stall_release", 64'(obs_ready), 64'b010);

        // Same-rd conflict between requesters 0 and 2 (ptr now 2 in round-robin).
        req_valid = 3'b101;
        req_rd[0] = 5'd7; req_data[0] = 32'h11;
        req_rd[2] = 5'd7; req_data[2] = 32'h22;
        cycle();
        if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        cycle();
        req_valid = '0;
        repeat (2) cycle();
        check_eq("conflict_rf", 64'(rf[7]), FIXED ? 64'h22 : 64'h11);

        // Randomized traffic; pending requests are held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && last_grant != i)) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_rd[i]    = 5'($urandom_range(0, 31));
                    req_data[i]  = W'($urandom);
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0; stall = 1'b0; req_valid = '0;
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
